logic_unit_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit for the ALU datapath. Accepts two WIDTH-bit operands and a 3-bit opcode under a valid/ready handshake, and returns the registered result plus zero, all-ones and parity flags two cycles later. It supersedes the fixed four-bit single-function gates and feeds the ALU result mux alongside the adder path.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/logic_unit_pipe_if.sv | 44 ++++
 rtl/logic_pipe_stage.sv | 52 +++++
 rtl/logic_unit_pipe.sv | 137 +++++++++++++
 tb/tb_logic_unit_pipe.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode encoding for the ALU datapath. It is shared by the
//               bitwise logic unit and the ALU top-level result mux.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Opcode for the bitwise logic unit.
  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_NOR  = 3'd2;
  localparam op_t OP_XOR  = 3'd3;
  localparam op_t OP_NAND = 3'd4;
  localparam op_t OP_XNOR = 3'd5;
  localparam op_t OP_NOT  = 3'd6;  // NOT A
  localparam op_t OP_PASS = 3'd7;  // PASS A

  // Width of the flag bundle that travels with the result in stage 2.
  // The bits are {parity, ones, zero}.
  localparam int FLAG_W = 3;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/logic_unit_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe_if
// Description : Handshake and data bundle for logic_unit_pipe.
//               master : upstream/downstream side, which drives the operands
//                        and out_ready.
//               slave  : the logic unit itself.
// Ports       : in_valid/in_ready, A_in, B_in, op_in, acc_sel, acc_clr,
//               out_valid/out_ready, logic_out, zero_flag, ones_flag,
//               parity_flag
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_unit_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  op_t              op_in;
  logic             acc_sel;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] logic_out;
  logic             zero_flag;
  logic             ones_flag;
  logic             parity_flag;

  modport master (
    output in_valid, A_in, B_in, op_in, acc_sel, acc_clr, out_ready,
    input  in_ready, out_valid, logic_out, zero_flag, ones_flag, parity_flag
  );

  modport slave (
    input  in_valid, A_in, B_in, op_in, acc_sel, acc_clr, out_ready,
    output in_ready, out_valid, logic_out, zero_flag, ones_flag, parity_flag
  );

endinterface : logic_unit_pipe_if
`default_nettype wire

// File: rtl/logic_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : logic_pipe_stage
// Description : Valid/ready register slice. The slice loads whenever it is
//               empty or its content is being taken downstream. Data is
//               captured only with a valid beat, so it holds steady while
//               the slice stalls or idles.
// Ports       : clk, rst (async, active-high)
//               in_valid, in_data, in_ready  - upstream side
//               out_valid, out_data, out_ready - downstream side
// Revision    : 1.0 - initial release
// ============================================================================
module logic_pipe_stage #(
  parameter int                DATA_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  wire                clk,
  input  wire                rst,
  input  wire                in_valid,
  input  wire   [DATA_W-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic  [DATA_W-1:0] out_data,
  input  wire                out_ready
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_load;

  // This path is combinational from out_ready only and never depends on
  // in_valid.
  assign w_load   = !r_valid || out_ready;
  assign in_ready = w_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VAL;
    end else if (w_load) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= in_data;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule : logic_pipe_stage
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe
// Description : Two-stage pipelined bitwise logic unit. S1 registers the
//               per-bit function of op_in on (A, B operand). S2 registers
//               that result together with zero/all-ones/parity flags taken
//               from the S1 result, so the flags always match logic_out.
//               Optional feature macro: LOGIC_UNIT_ACC_EN. It adds a WIDTH-bit
//               accumulator that can replace B_in (acc_sel) and can be
//               cleared (acc_clr).
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - logic_unit_pipe_if.slave (handshake, operands, result)
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire                clk,
  input  wire                rst,
  logic_unit_pipe_if.slave   bus
);

  // S2 resets to logic_out=0. Its flags then read zero=1, ones=0, parity=0.
  localparam logic [WIDTH+FLAG_W-1:0] C_S2_RESET = {3'b001, {WIDTH{1'b0}}};

  logic [WIDTH-1:0]        w_b_operand;
  logic [WIDTH-1:0]        w_result;
  logic                    w_s1_in_ready;
  logic                    w_s1_valid;
  logic [WIDTH-1:0]        w_s1_data;
  logic                    w_s2_in_ready;
  logic                    w_zero;
  logic                    w_ones;
  logic                    w_parity;
  logic [WIDTH+FLAG_W-1:0] w_s2_data;

  // --------------------------------------------------------------------------
  // B operand selection
  // --------------------------------------------------------------------------
`ifdef LOGIC_UNIT_ACC_EN
  logic             w_accept;
  logic [WIDTH-1:0] r_acc;

  assign w_accept    = bus.in_valid && w_s1_in_ready;
  // A beat reads the accumulator as it is at accept time. The beat that
  // arrives together with a clear therefore still sees the old value.
  assign w_b_operand = bus.acc_sel ? r_acc : bus.B_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (bus.acc_clr) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= w_result;
    end
  end
`else
  logic w_unused_acc;

  assign w_unused_acc = bus.acc_sel ^ bus.acc_clr;
  assign w_b_operand  = bus.B_in;
`endif

  // --------------------------------------------------------------------------
  // Bitwise function
  // --------------------------------------------------------------------------
  always_comb begin
    w_result = '0;
    case (bus.op_in)
      OP_AND:  w_result =   bus.A_in & w_b_operand;
      OP_OR:   w_result =   bus.A_in | w_b_operand;
      OP_NOR:  w_result = ~(bus.A_in | w_b_operand);
      OP_XOR:  w_result =   bus.A_in ^ w_b_operand;
      OP_NAND: w_result = ~(bus.A_in & w_b_operand);
      OP_XNOR: w_result = ~(bus.A_in ^ w_b_operand);
      OP_NOT:  w_result =  ~bus.A_in;
      OP_PASS: w_result =   bus.A_in;
      default: w_result = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Stage 1: result only
  // --------------------------------------------------------------------------
  logic_pipe_stage #(
    .DATA_W    (WIDTH),
    .RESET_VAL ({WIDTH{1'b0}})
  ) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_data   (w_result),
    .in_ready  (w_s1_in_ready),
    .out_valid (w_s1_valid),
    .out_data  (w_s1_data),
    .out_ready (w_s2_in_ready)
  );

  // --------------------------------------------------------------------------
  // Flags are computed from the S1 result, ahead of the S2 register.
  // --------------------------------------------------------------------------
  assign w_zero    = (w_s1_data == '0);
  assign w_ones    = &w_s1_data;
  assign w_parity  = ^w_s1_data;
  assign w_s2_data = {w_parity, w_ones, w_zero, w_s1_data};

  // --------------------------------------------------------------------------
  // Stage 2: result and flags
  // --------------------------------------------------------------------------
  logic [WIDTH+FLAG_W-1:0] w_s2_q;

  logic_pipe_stage #(
    .DATA_W    (WIDTH + FLAG_W),
    .RESET_VAL (C_S2_RESET)
  ) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_s1_valid),
    .in_data   (w_s2_data),
    .in_ready  (w_s2_in_ready),
    .out_valid (bus.out_valid),
    .out_data  (w_s2_q),
    .out_ready (bus.out_ready)
  );

  assign bus.in_ready    = w_s1_in_ready;
  assign bus.logic_out   = w_s2_q[WIDTH-1:0];
  assign bus.zero_flag   = w_s2_q[WIDTH];
  assign bus.ones_flag   = w_s2_q[WIDTH+1];
  assign bus.parity_flag = w_s2_q[WIDTH+2];

endmodule : logic_unit_pipe
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_pipe
// Description : Directed self-checking bench for logic_unit_pipe. It uses a
//               WIDTH=4 instance and a WIDTH=16 instance that share the
//               clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(4))  bus4 ();
  logic_unit_pipe_if #(.WIDTH(16)) bus16 ();

  logic_unit_pipe #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  logic_unit_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus4.in_valid  = 1'b0; bus4.A_in  = '0; bus4.B_in  = '0; bus4.op_in  = OP_AND;
    bus4.acc_sel   = 1'b0; bus4.acc_clr = 1'b0; bus4.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.A_in = '0; bus16.B_in = '0; bus16.op_in = OP_AND;
    bus16.acc_sel  = 1'b0; bus16.acc_clr = 1'b0; bus16.out_ready = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (bus4.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus4.out_valid); else n_pass++;
    n_checks++; if (bus4.logic_out !== 4'h0) $display("FAIL rst_logic_out got=%h exp=0", bus4.logic_out); else n_pass++;
    n_checks++; if ({bus4.zero_flag, bus4.ones_flag, bus4.parity_flag} !== 3'b100)
      $display("FAIL rst_flags got=%b exp=100", {bus4.zero_flag, bus4.ones_flag, bus4.parity_flag}); else n_pass++;
    n_checks++; if (bus4.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", bus4.in_ready); else n_pass++;
    n_checks++; if ({bus16.logic_out, bus16.zero_flag} !== {16'h0, 1'b1})
      $display("FAIL rst_wide got=%h/%b exp=0000/1", bus16.logic_out, bus16.zero_flag); else n_pass++;
    rst = 1'b0;
    tick();
    // Fill both stages, then assert reset between clock edges.
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1; bus4.op_in = OP_PASS; bus4.A_in = 4'b0101;
    tick(); tick();
    bus4.in_valid  = 1'b0;
    n_checks++; if ({bus4.out_valid, bus4.in_ready, bus4.logic_out} !== {1'b1, 1'b0, 4'b0101})
      $display("FAIL midrst_pre got=%b%b/%b exp=10/0101", bus4.out_valid, bus4.in_ready, bus4.logic_out); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus4.out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b exp=0", bus4.out_valid); else n_pass++;
    n_checks++; if (bus4.logic_out !== 4'h0) $display("FAIL midrst_logic_out got=%b exp=0000", bus4.logic_out); else n_pass++;
    n_checks++; if (bus4.zero_flag !== 1'b1) $display("FAIL midrst_zero got=%b exp=1", bus4.zero_flag); else n_pass++;
    n_checks++; if (bus4.in_ready !== 1'b1) $display("FAIL midrst_in_ready got=%b exp=1", bus4.in_ready); else n_pass++;
    tick();
    rst = 1'b0;
    bus4.out_ready = 1'b1;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_op_sweep;
    logic [3:0] exp_out [8];
    logic       exp_par [8];
    exp_out = '{4'b1000, 4'b1110, 4'b0001, 4'b0110, 4'b0111, 4'b1001, 4'b0011, 4'b1100};
    exp_par = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        bus4.in_valid = 1'b1; bus4.A_in = 4'b1100; bus4.B_in = 4'b1010; bus4.op_in = op_t'(i);
        n_checks++; if (bus4.in_ready !== 1'b1) $display("FAIL sweep_in_ready[%0d] got=%b exp=1", i, bus4.in_ready); else n_pass++;
      end else begin
        bus4.in_valid = 1'b0;
      end
      tick();
      if (i == 0 || i == 9) begin
        n_checks++; if (bus4.out_valid !== 1'b0) $display("FAIL sweep_idle_valid[%0d] got=%b exp=0", i, bus4.out_valid); else n_pass++;
      end else begin
        n_checks++; if ({bus4.out_valid, bus4.logic_out, bus4.parity_flag} !== {1'b1, exp_out[i-1], exp_par[i-1]})
          $display("FAIL sweep_op%0d got=%b/%b/%b exp=1/%b/%b", i-1, bus4.out_valid, bus4.logic_out,
                   bus4.parity_flag, exp_out[i-1], exp_par[i-1]); else n_pass++;
      end
    end
    // NOR of zeros gives all ones. AND of disjoint bits gives zero.
    bus4.in_valid = 1'b1; bus4.A_in = 4'b0000; bus4.B_in = 4'b0000; bus4.op_in = OP_NOR;
    tick();
    bus4.A_in = 4'b0101; bus4.B_in = 4'b1010; bus4.op_in = OP_AND;
    tick();
    bus4.in_valid = 1'b0;
    n_checks++; if ({bus4.logic_out, bus4.zero_flag, bus4.ones_flag, bus4.parity_flag} !== 7'b1111_010)
      $display("FAIL nor_zero_ones got=%b/%b%b%b exp=1111/010", bus4.logic_out, bus4.zero_flag,
               bus4.ones_flag, bus4.parity_flag); else n_pass++;
    tick();
    n_checks++; if ({bus4.logic_out, bus4.zero_flag, bus4.ones_flag, bus4.parity_flag} !== 7'b0000_100)
      $display("FAIL and_zero got=%b/%b%b%b exp=0000/100", bus4.logic_out, bus4.zero_flag,
               bus4.ones_flag, bus4.parity_flag); else n_pass++;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure;
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1; bus4.op_in = OP_PASS; bus4.A_in = 4'd1;
    tick();
    bus4.A_in = 4'd2;
    n_checks++; if (bus4.in_ready !== 1'b1) $display("FAIL bp_second_ready got=%b exp=1", bus4.in_ready); else n_pass++;
    tick();
    bus4.A_in = 4'd3;
    n_checks++; if ({bus4.in_ready, bus4.out_valid, bus4.logic_out} !== {1'b0, 1'b1, 4'd1})
      $display("FAIL bp_full got=%b%b/%h exp=01/1", bus4.in_ready, bus4.out_valid, bus4.logic_out); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if ({bus4.in_ready, bus4.logic_out} !== {1'b0, 4'd1})
        $display("FAIL bp_hold[%0d] got=%b/%h exp=0/1", k, bus4.in_ready, bus4.logic_out); else n_pass++;
    end
    bus4.out_ready = 1'b1;
    #1;
    n_checks++; if (bus4.in_ready !== 1'b1) $display("FAIL bp_reopen got=%b exp=1", bus4.in_ready); else n_pass++;
    tick();
    bus4.in_valid = 1'b0;
    n_checks++; if ({bus4.out_valid, bus4.logic_out} !== {1'b1, 4'd2})
      $display("FAIL bp_beat2 got=%b/%h exp=1/2", bus4.out_valid, bus4.logic_out); else n_pass++;
    tick();
    n_checks++; if ({bus4.out_valid, bus4.logic_out} !== {1'b1, 4'd3})
      $display("FAIL bp_beat3 got=%b/%h exp=1/3", bus4.out_valid, bus4.logic_out); else n_pass++;
    tick();
    n_checks++; if (bus4.out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", bus4.out_valid); else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back;
    logic [3:0] got     [6];
    int         got_cyc [6];
    int         n_got;
    int         next_val;
    logic       accepted;
    n_got = 0;
    // Fill both stages with beats 1 and 2 while out_ready is low.
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1; bus4.op_in = OP_PASS; bus4.A_in = 4'd1;
    tick();
    bus4.A_in = 4'd2;
    tick();
    next_val = 3;
    for (int cyc = 0; cyc < 20 && n_got < 6; cyc++) begin
      bus4.out_ready = 1'b1;
      bus4.in_valid  = (next_val <= 6);
      bus4.A_in      = 4'(next_val);
      #1;
      if (bus4.out_valid && bus4.out_ready) begin
        got[n_got]     = bus4.logic_out;
        got_cyc[n_got] = cyc;
        n_got++;
      end
      accepted = bus4.in_valid && bus4.in_ready;
      tick();
      if (accepted) next_val++;
    end
    bus4.in_valid = 1'b0;
    n_checks++; if (n_got !== 6) $display("FAIL b2b_count got=%0d exp=6", n_got); else n_pass++;
    if (n_got == 6) begin
      for (int k = 0; k < 6; k++) begin
        n_checks++; if (got[k] !== 4'(k + 1)) $display("FAIL b2b_order[%0d] got=%0d exp=%0d", k, got[k], k + 1); else n_pass++;
      end
      n_checks++; if (got_cyc[5] - got_cyc[0] !== 5)
        $display("FAIL b2b_bubble span got=%0d exp=5", got_cyc[5] - got_cyc[0]); else n_pass++;
    end
    tick(); tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_wide;
    bus16.out_ready = 1'b1;
    bus16.in_valid  = 1'b1; bus16.A_in = 16'hFFFF; bus16.B_in = 16'h00FF; bus16.op_in = OP_XOR;
    tick();
    bus16.op_in = OP_OR;
    tick();
    bus16.in_valid = 1'b0;
    n_checks++; if ({bus16.out_valid, bus16.logic_out, bus16.zero_flag, bus16.ones_flag, bus16.parity_flag}
                    !== {1'b1, 16'hFF00, 3'b000})
      $display("FAIL wide_xor got=%b/%h/%b%b%b exp=1/ff00/000", bus16.out_valid, bus16.logic_out,
               bus16.zero_flag, bus16.ones_flag, bus16.parity_flag); else n_pass++;
    tick();
    n_checks++; if ({bus16.logic_out, bus16.zero_flag, bus16.ones_flag, bus16.parity_flag} !== {16'hFFFF, 3'b010})
      $display("FAIL wide_or got=%h/%b%b%b exp=ffff/010", bus16.logic_out, bus16.zero_flag,
               bus16.ones_flag, bus16.parity_flag); else n_pass++;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_accumulator;
    op_t        ops [6];
    logic [3:0] a_v [6];
    logic [3:0] b_v [6];
    logic       sel [6];
    logic       clr [6];
    logic [3:0] exp_out [6];
    ops = '{OP_OR, OP_OR, OP_PASS, OP_OR, OP_OR, OP_OR};
    a_v = '{4'b0001, 4'b0010, 4'b1000, 4'b0100, 4'b0001, 4'b0010};
    b_v = '{4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b1000, 4'b0000};
    sel = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    clr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef LOGIC_UNIT_ACC_EN
    exp_out = '{4'b0001, 4'b0011, 4'b1000, 4'b0100, 4'b0101, 4'b0010};
`else
    exp_out = '{4'b0001, 4'b0110, 4'b1000, 4'b0101, 4'b1001, 4'b0010};
`endif
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        bus4.in_valid = 1'b1; bus4.op_in = ops[i]; bus4.A_in = a_v[i]; bus4.B_in = b_v[i];
        bus4.acc_sel  = sel[i]; bus4.acc_clr = clr[i];
      end else begin
        bus4.in_valid = 1'b0; bus4.acc_sel = 1'b0; bus4.acc_clr = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 6) begin
        n_checks++; if ({bus4.out_valid, bus4.logic_out} !== {1'b1, exp_out[i-1]})
          $display("FAIL acc_beat%0d got=%b/%b exp=1/%b", i-1, bus4.out_valid, bus4.logic_out, exp_out[i-1]); else n_pass++;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_op_sweep();
    test_backpressure();
    test_back_to_back();
    test_wide();
    test_accumulator();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_logic_unit_pipe
`default_nettype wire
